// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment display arbiter.
// Segment bit order is gfedcba (bit0 = a ... bit6 = g), active high.
package seg_pkg;

  localparam int unsigned SEG_W = 7;
  localparam int unsigned HEX_W = 4;

  typedef logic [SEG_W-1:0] seg_t;

  // Dash (segment g only), shown whenever nobody owns the display.
  localparam seg_t IDLE_PATTERN_DEFAULT = 7'b1000000;

  // Hex-to-segment table; element d holds the pattern for digit d.
  localparam logic [15:0][SEG_W-1:0] HEX_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational 4-to-7 hex digit decoder driven by the package lookup table.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [HEX_W-1:0] hex_i,
  output logic [SEG_W-1:0] seg_c
);

  assign seg_c = HEX_TABLE[hex_i];

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin arbiter sharing one 7-segment display among N_REQ requesters;
// each granted digit is held for exactly HOLD_CYCLES clocks.
module seg_display_arbiter
  import seg_pkg::*;
#(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned HOLD_CYCLES  = 16,
  parameter logic [6:0]  IDLE_PATTERN = IDLE_PATTERN_DEFAULT,
  localparam int unsigned OW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [HEX_W*N_REQ-1:0]   digit,
  output logic [N_REQ-1:0]         grant,
  output logic                     busy,
  output logic [OW-1:0]            owner,
  output logic [SEG_W-1:0]         segments
);

  localparam int unsigned CW = $clog2(HOLD_CYCLES);

  state_e             state_q, state_d;
  logic [OW-1:0]      ptr_q, ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [HEX_W-1:0]   digit_q, digit_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [OW-1:0]      owner_q, owner_d;
  logic               busy_q, busy_d;
  logic [SEG_W-1:0]   seg_q, seg_d;

  logic [OW-1:0]      win_idx;
  logic               found;
  logic               arb_fire;
  logic [SEG_W-1:0]   dec_seg_c;

  // First requester at or after ptr, wrapping modulo N_REQ.
  always_comb begin
    win_idx = ptr_q;
    found   = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      int unsigned cand;
      logic [OW-1:0] cand_idx;
      cand     = (32'(ptr_q) + k) % N_REQ;
      cand_idx = OW'(cand);
      if (!found && req[cand_idx]) begin
        found   = 1'b1;
        win_idx = cand_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      digit_q <= '0;
      grant_q <= '0;
      owner_q <= '0;
      busy_q  <= 1'b0;
      seg_q   <= IDLE_PATTERN;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
      seg_q   <= seg_d;
    end
  end

  // Next state: arbitrate from IDLE, or back-to-back when the hold expires.
  always_comb begin
    state_d  = state_q;
    arb_fire = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          arb_fire = 1'b1;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          if (found) arb_fire = 1'b1;
          else       state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Register inputs for grant, owner, latched digit, counter and segments.
  always_comb begin
    grant_d = '0;
    owner_d = owner_q;
    digit_d = digit_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    busy_d  = busy_q;
    seg_d   = seg_q;
    if (arb_fire) begin
      grant_d = N_REQ'(1) << win_idx;
      owner_d = win_idx;
      digit_d = digit[HEX_W*win_idx +: HEX_W];
      cnt_d   = CW'(HOLD_CYCLES - 1);
      ptr_d   = (win_idx == OW'(N_REQ - 1)) ? '0 : win_idx + OW'(1);
      busy_d  = 1'b1;
      seg_d   = dec_seg_c;
    end else if (state_q == HOLD) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CW'(1);
      end else begin
        busy_d = 1'b0;
        seg_d  = IDLE_PATTERN;
      end
    end
  end

  seg_hex_decode u_dec (
    .hex_i (digit_d),
    .seg_c (dec_seg_c)
  );

  assign grant    = grant_q;
  assign busy     = busy_q;
  assign owner    = owner_q;
  assign segments = seg_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Scoreboard bench for seg_display_arbiter (N_REQ=4, HOLD_CYCLES=4).
module tb_seg_display_arbiter;
  import seg_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] digit;
  logic [3:0]  grant;
  logic        busy;
  logic [1:0]  owner;
  logic [6:0]  segments;

  always #5 clk = ~clk;

  seg_display_arbiter #(
    .N_REQ        (4),
    .HOLD_CYCLES  (4),
    .IDLE_PATTERN (7'b1000000)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .digit    (digit),
    .grant    (grant),
    .busy     (busy),
    .owner    (owner),
    .segments (segments)
  );

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] o;
    logic [6:0] s;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [3:0] g, input logic [1:0] o, input logic [6:0] s);
    exp_t e;
    e.g = g;
    e.o = o;
    e.s = s;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Segments held for exactly four cycles, then the dash with busy low.
  task automatic hold_check(input logic [6:0] seg, input logic [1:0] own);
    for (int j = 0; j < 4; j++) begin
      if (j > 0) @(negedge clk);
      chk("hold_seg_busy", {busy, segments}, {1'b1, seg});
    end
    @(negedge clk);
    chk("hold_end_idle", {grant, busy, segments}, {4'b0, 1'b0, 7'h40});
    chk("owner_retained", owner, own);
  endtask

  // Monitor: every grant pulse pops one expected arbitration result.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && grant != 4'b0) begin
      if (sb.size() == 0) begin
        chk("unexpected_grant", grant, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("grant", grant, mon_e.g);
        chk("owner", owner, mon_e.o);
        chk("seg_on_grant", segments, mon_e.s);
        chk("busy_on_grant", busy, 1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, %0d checks", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req   = '0;
    digit = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_after_reset", {grant, busy, owner, segments}, {4'b0, 1'b0, 2'd0, 7'h40});
    end

    // Single request, dropped after grant
    digit[11:8] = 4'h7;
    push(4'b0100, 2'd2, 7'h07);
    req = 4'b0100;
    @(negedge clk);
    req = '0;
    hold_check(7'h07, 2'd2);

    // All four requesting, held high: 0,1,2,3,0 back-to-back
    do_reset();
    digit = 16'h4321;
    push(4'b0001, 2'd0, 7'h06);
    push(4'b0010, 2'd1, 7'h5B);
    push(4'b0100, 2'd2, 7'h4F);
    push(4'b1000, 2'd3, 7'h66);
    push(4'b0001, 2'd0, 7'h06);
    req = 4'hF;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("rr_busy", busy, 1);
      chk("rr_grant_timing", 32'(grant != 4'b0), 32'(i % 4 == 0));
      if (i == 17) req = '0;
    end
    @(negedge clk);
    chk("rr_end_idle", {busy, segments}, {1'b0, 7'h40});

    // Pointer wrap: grant 3, then 4'b1001 -> 0 then 3
    do_reset();
    push(4'b1000, 2'd3, 7'h66);
    push(4'b0001, 2'd0, 7'h06);
    push(4'b1000, 2'd3, 7'h66);
    req = 4'b1000;
    @(negedge clk);
    req = 4'b1001;
    repeat (4) @(negedge clk);
    chk("wrap_owner0", owner, 0);
    repeat (4) @(negedge clk);
    chk("wrap_owner3", owner, 3);
    req = '0;
    repeat (4) @(negedge clk);
    chk("wrap_end_idle", {busy, segments}, {1'b0, 7'h40});

    // Owner changes digit during hold
    digit[3:0] = 4'h7;
    push(4'b0001, 2'd0, 7'h07);
    req = 4'b0001;
    @(negedge clk);
    req = '0;
    digit[3:0] = 4'hF;
    hold_check(7'h07, 2'd0);

    // Asynchronous reset mid-hold, then arbitration restarts at 0
    digit[7:4] = 4'h5;
    push(4'b0010, 2'd1, 7'h6D);
    req = 4'b0010;
    @(negedge clk);
    req = '0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", {grant, busy, owner, segments}, {4'b0, 1'b0, 2'd0, 7'h40});
    @(negedge clk);
    rst_n = 1'b1;
    push(4'b0001, 2'd0, 7'h71);
    req = 4'hF;
    @(negedge clk);
    req = '0;
    repeat (5) @(negedge clk);
    chk("post_reset_idle", {busy, segments}, {1'b0, 7'h40});

    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_display_arbiter.md
Name: seg_display_arbiter

Overview:
- Shares the single 7-segment display (uo_out[6:0]) between N_REQ internal requesters.
- Each requester presents a 4-bit hex digit. A round-robin arbiter grants the display to one requester, latches its digit and holds it for HOLD_CYCLES clocks, then re-arbitrates.
- Sits inside tt_um_fpga_hdl_demo between the demo logic and uo_out[6:0]; drives the pins directly.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- HOLD_CYCLES, 16, clocks each granted digit stays displayed (>= 2).
- IDLE_PATTERN, 7'b1000000, segment pattern shown when no owner (dash, segment g only).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N_REQ  level request per requester; digit must be stable while req is high.
- digit  input  4*N_REQ  hex digit per requester; requester i uses bits [4i+3:4i].
- grant  output  N_REQ  one-hot, one-cycle pulse: the requester's digit was latched this cycle.
- busy  output  1  high while a digit is being held (state HOLD).
- owner  output  clog2(N_REQ)  index of the current or most recent owner.
- segments  output  7  active-high segments; bit0=a, bit1=b, ... bit6=g.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, grant=0, busy=0, owner=0.
  - Round-robin pointer ptr=0, hold counter=0, latched digit=0.
  - segments=IDLE_PATTERN.
  - Takes effect immediately, including mid-HOLD; the held digit is lost.
- States: IDLE, HOLD. All outputs are registered.
- IDLE, any req high, at the clock edge:
  - Winner = first i with req[i]=1, searching ptr, ptr+1, ... modulo N_REQ.
  - grant[winner]=1 for exactly that cycle; owner=winner; latch digit[winner].
  - segments=hex-decode(latched digit); counter=HOLD_CYCLES-1; ptr=(winner+1) mod N_REQ; busy=1; state=HOLD.
  - Latency: req sampled high at edge t, so grant/segments/busy are valid after edge t (visible in cycle t+1).
- IDLE, no req: outputs unchanged, segments=IDLE_PATTERN, grant=0.
- HOLD:
  - grant=0. Counter decrements each cycle while nonzero.
  - On the edge where counter==0: if any req high, arbitrate immediately as in IDLE. The new digit replaces the old with no idle gap, and busy stays 1.
  - Otherwise state=IDLE, busy=0, segments=IDLE_PATTERN, owner retained.
  - Total display time per grant = HOLD_CYCLES clocks exactly.
- Requester rule: deassert req within HOLD_CYCLES-1 cycles after its grant pulse. A req still high at re-arbitration is treated as a new request, and round-robin ordering still applies.
- Changes to digit[] of the owner during HOLD have no effect.
- Decode table (gfedcba):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Simultaneous requests: exactly one grant bit per arbitration; no bit of grant is ever asserted outside an arbitration edge.
- ptr wrap: winner N_REQ-1 sets ptr=0.

Decomposition:
- Package seg_pkg holds:
  - 16-entry hex-to-segment constant table.
  - IDLE_PATTERN default.
  - State enum {IDLE, HOLD}.
- One sub-module, seg_hex_decode: combinational 4-to-7 lookup using the package table, feeding the segments register.
- Round-robin search stays inline in seg_display_arbiter.

Test Plan (N_REQ=4, HOLD_CYCLES=4):
- Reset release with req=0 -> segments=0x40, busy=0, grant=0, owner=0 for 20 cycles.
- req[2]=1, digit2=0x7, dropped after grant -> grant=4'b0100 for one cycle, segments=0x07 for exactly 4 cycles, then 0x40 and busy=0.
- req=4'b1111, digits 1,2,3,4, held high -> grants in order 0,1,2,3,0 every 4 cycles; segments 0x06,0x5B,0x4F,0x66 back-to-back with busy never dropping.
- ptr wrap: grant to requester 3, then req=4'b1001 -> next grant goes to 0, then 3.
- Owner changes digit mid-HOLD (0x7 to 0xF) -> segments stay 0x07 for the full hold.
- rst_n pulsed low mid-HOLD -> segments=0x40, busy=0, grant=0 asynchronously; after release, arbitration restarts from requester 0.
